// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one response out.
// A per-transaction cycle budget abandons a stuck slave and reports a timeout response.
module axil_cfg_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    localparam logic [31:0] TmoLimit = 32'(C_TIMEOUT_CYCLES);

    state_e                            state_q;
    logic                              cmd_ready_q;
    logic                              awvalid_q;
    logic                              wvalid_q;
    logic                              bready_q;
    logic                              arvalid_q;
    logic                              rready_q;
    logic                              aw_done_q;
    logic                              w_done_q;
    logic                              rsp_valid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                        rsp_resp_q;
    logic                              rsp_timeout_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [31:0]                       tmo_cnt_q;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_done_now;
    logic        w_done_now;
    logic [31:0] tmo_cnt_inc;
    logic        tmo_hit;
    logic        phase_done;
    logic        tmo_fire;

    assign aw_hs       = awvalid_q & M_AXI_AWREADY;
    assign w_hs        = wvalid_q & M_AXI_WREADY;
    assign aw_done_now = aw_done_q | aw_hs;
    assign w_done_now  = w_done_q | w_hs;

    // Saturating count of cycles spent waiting on the slave for this transaction.
    assign tmo_cnt_inc = (tmo_cnt_q == 32'hFFFF_FFFF) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
    assign tmo_hit     = (TmoLimit != 32'd0) && (tmo_cnt_inc == TmoLimit);

    // A phase that completes in the limit cycle takes priority over the timeout.
    always_comb begin
        phase_done = 1'b1;
        case (state_q)
            StWrReq:  phase_done = aw_done_now & w_done_now;
            StWrResp: phase_done = M_AXI_BVALID & bready_q;
            StRdReq:  phase_done = M_AXI_ARREADY & arvalid_q;
            StRdResp: phase_done = M_AXI_RVALID & rready_q;
            default:  phase_done = 1'b1;
        endcase
    end

    assign tmo_fire = tmo_hit & ~phase_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        tmo_cnt_q   <= '0;
                        if (cmd_write) begin
                            state_q   <= StWrReq;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= StRdReq;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StWrReq: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_now && w_done_now) begin
                        state_q  <= StWrResp;
                        bready_q <= 1'b1;
                    end
                end
                StWrResp: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (M_AXI_BVALID && bready_q) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= M_AXI_BRESP;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StRsp;
                    end
                end
                StRdReq: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (M_AXI_ARREADY && arvalid_q) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdResp;
                    end
                end
                StRdResp: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (M_AXI_RVALID && rready_q) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= M_AXI_RDATA;
                        rsp_resp_q    <= M_AXI_RRESP;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StRsp;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Abandon the transaction; valids drop without a handshake (debug recovery only).
            if (tmo_fire) begin
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                bready_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= '0;
                rsp_resp_q    <= 2'b10;
                rsp_timeout_q <= 1'b1;
                state_q       <= StRsp;
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = (state_q != StIdle);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: scripted AXI-Lite slave with cycle-exact checks,
// plus a response scoreboard fed when each command is issued.
module tb_axil_cfg_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    axil_cfg_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_TIMEOUT_CYCLES   (16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("rsp_rdata", rsp_rdata, e.rdata);
                check_val("rsp_resp", rsp_resp, e.resp);
                check_val("rsp_timeout", rsp_timeout, e.tmo);
            end
        end
    end

    // Drives one command through acceptance; returns in cycle T+1.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] e_rdata,
                         input logic [1:0] e_resp, input logic e_tmo, input bit push);
        exp_t e;
        check_val("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        if (push) begin
            e.rdata = e_rdata;
            e.resp  = e_resp;
            e.tmo   = e_tmo;
            exp_q.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("rsp_valid_after_consume", rsp_valid, 1'b0);
        check_val("cmd_ready_after_consume", cmd_ready, 1'b1);
    endtask

    task automatic write_zw(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        issue(1'b1, addr, data, strb, 32'h0, 2'b00, 1'b0, 1'b1);
        check_val("wzw_awvalid_t1", M_AXI_AWVALID, 1'b1);
        check_val("wzw_wvalid_t1", M_AXI_WVALID, 1'b1);
        check_val("wzw_awaddr", M_AXI_AWADDR, addr);
        check_val("wzw_wdata", M_AXI_WDATA, data);
        check_val("wzw_wstrb", M_AXI_WSTRB, strb);
        check_val("wzw_bready_t1", M_AXI_BREADY, 1'b0);
        step();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        check_val("wzw_awvalid_t2", M_AXI_AWVALID, 1'b0);
        check_val("wzw_wvalid_t2", M_AXI_WVALID, 1'b0);
        check_val("wzw_bready_t2", M_AXI_BREADY, 1'b1);
        step();
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b00;
        check_val("wzw_bready_t3", M_AXI_BREADY, 1'b1);
        check_val("wzw_rsp_valid_t3", rsp_valid, 1'b0);
        step();
        M_AXI_BVALID = 1'b0;
        check_val("wzw_rsp_valid_t4", rsp_valid, 1'b1);
        check_val("wzw_bready_t4", M_AXI_BREADY, 1'b0);
        consume_rsp();
    endtask

    task automatic read_zw(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = data;
        M_AXI_RRESP   = resp;
        issue(1'b0, addr, 32'h0, 4'h0, data, resp, 1'b0, 1'b1);
        check_val("rzw_arvalid_t1", M_AXI_ARVALID, 1'b1);
        check_val("rzw_araddr", M_AXI_ARADDR, addr);
        check_val("rzw_rready_t1", M_AXI_RREADY, 1'b0);
        step();
        M_AXI_ARREADY = 1'b0;
        check_val("rzw_arvalid_t2", M_AXI_ARVALID, 1'b0);
        check_val("rzw_rready_t2", M_AXI_RREADY, 1'b1);
        check_val("rzw_rsp_valid_t2", rsp_valid, 1'b0);
        step();
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = '0;
        M_AXI_RRESP  = 2'b00;
        check_val("rzw_rsp_valid_t3", rsp_valid, 1'b1);
        check_val("rzw_rready_t3", M_AXI_RREADY, 1'b0);
        consume_rsp();
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY = 1'b0;
        M_AXI_BRESP = 2'b00;
        M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA = '0;
        M_AXI_RRESP = 2'b00;
        M_AXI_RVALID = 1'b0;

        // Reset state
        repeat (3) step();
        check_val("rst_cmd_ready", cmd_ready, 1'b0);
        check_val("rst_awvalid", M_AXI_AWVALID, 1'b0);
        check_val("rst_wvalid", M_AXI_WVALID, 1'b0);
        check_val("rst_bready", M_AXI_BREADY, 1'b0);
        check_val("rst_arvalid", M_AXI_ARVALID, 1'b0);
        check_val("rst_rready", M_AXI_RREADY, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_val("rst_rsp_resp", rsp_resp, 2'b00);
        check_val("rst_rsp_timeout", rsp_timeout, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_awaddr", M_AXI_AWADDR, 32'h0);
        check_val("rst_wdata", M_AXI_WDATA, 32'h0);
        check_val("rst_wstrb", M_AXI_WSTRB, 4'h0);
        reset = 1'b0;
        check_val("rst_release_cmd_ready", cmd_ready, 1'b0);
        step();
        check_val("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write and read
        write_zw(32'h0000_0010, 32'hA5A5_0001, 4'hF);
        read_zw(32'h0000_0040, 32'h1234_5678, 2'b01);

        // Write: W accepted at T+1, AW delayed to T+4, slave returns SLVERR
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b1;
        issue(1'b1, 32'h0000_0024, 32'h5A5A_0002, 4'h3, 32'h0, 2'b10, 1'b0, 1'b1);
        check_val("wd_awvalid_t1", M_AXI_AWVALID, 1'b1);
        check_val("wd_wvalid_t1", M_AXI_WVALID, 1'b1);
        check_val("wd_wstrb", M_AXI_WSTRB, 4'h3);
        step();
        M_AXI_WREADY = 1'b0;
        check_val("wd_wvalid_t2", M_AXI_WVALID, 1'b0);
        check_val("wd_awvalid_t2", M_AXI_AWVALID, 1'b1);
        check_val("wd_bready_t2", M_AXI_BREADY, 1'b0);
        step();
        check_val("wd_awvalid_t3", M_AXI_AWVALID, 1'b1);
        check_val("wd_awaddr_t3", M_AXI_AWADDR, 32'h0000_0024);
        check_val("wd_bready_t3", M_AXI_BREADY, 1'b0);
        step();
        check_val("wd_awvalid_t4", M_AXI_AWVALID, 1'b1);
        check_val("wd_bready_t4", M_AXI_BREADY, 1'b0);
        M_AXI_AWREADY = 1'b1;
        step();
        M_AXI_AWREADY = 1'b0;
        check_val("wd_awvalid_t5", M_AXI_AWVALID, 1'b0);
        check_val("wd_bready_t5", M_AXI_BREADY, 1'b1);
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = 2'b10;
        step();
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        check_val("wd_rsp_valid_t6", rsp_valid, 1'b1);
        check_val("wd_bready_t6", M_AXI_BREADY, 1'b0);
        consume_rsp();

        // Read with AR delayed and 5 wait cycles before R
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        issue(1'b0, 32'h2000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check_val("rw_arvalid_hold", M_AXI_ARVALID, 1'b1);
            check_val("rw_araddr_hold", M_AXI_ARADDR, 32'h2000_0004);
            check_val("rw_rready_early", M_AXI_RREADY, 1'b0);
            step();
        end
        check_val("rw_arvalid_t3", M_AXI_ARVALID, 1'b1);
        check_val("rw_araddr_t3", M_AXI_ARADDR, 32'h2000_0004);
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("rw_rready_wait", M_AXI_RREADY, 1'b1);
            check_val("rw_arvalid_wait", M_AXI_ARVALID, 1'b0);
            check_val("rw_rsp_valid_wait", rsp_valid, 1'b0);
            step();
        end
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = 32'hDEAD_BEEF;
        step();
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = '0;
        check_val("rw_rsp_valid", rsp_valid, 1'b1);
        check_val("rw_rready_done", M_AXI_RREADY, 1'b0);
        consume_rsp();

        // Read that never sees ARREADY: abandoned after 16 cycles
        issue(1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            check_val("tmo_arvalid_hold", M_AXI_ARVALID, 1'b1);
            step();
        end
        check_val("tmo_arvalid_drop", M_AXI_ARVALID, 1'b0);
        check_val("tmo_rready", M_AXI_RREADY, 1'b0);
        check_val("tmo_rsp_valid", rsp_valid, 1'b1);
        check_val("tmo_busy", busy, 1'b1);
        consume_rsp();
        read_zw(32'h3000_0008, 32'h0BAD_F00D, 2'b00);

        // Reset while in WR_RESP: no response, clean recovery
        M_AXI_AWREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        issue(1'b1, 32'h0000_0050, 32'h0000_0077, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0);
        step();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        check_val("mr_bready_pre", M_AXI_BREADY, 1'b1);
        reset = 1'b1;
        step();
        check_val("mr_bready", M_AXI_BREADY, 1'b0);
        check_val("mr_busy", busy, 1'b0);
        check_val("mr_rsp_valid", rsp_valid, 1'b0);
        check_val("mr_cmd_ready", cmd_ready, 1'b0);
        check_val("mr_awaddr", M_AXI_AWADDR, 32'h0);
        reset = 1'b0;
        step();
        check_val("mr_cmd_ready_after", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_val("mr_no_rsp", rsp_valid, 1'b0);
            step();
        end
        read_zw(32'h0000_0060, 32'hCAFE_0042, 2'b00);

        step();
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
